// File: rtl/mwr_tlp_sender_if.sv
// Handshake bundle between the AW/W FWFT FIFOs, the MWr TLP sender and the
// data-link-layer beat stream.
// Ports: hdr_* (header FIFO), wd_* (payload FIFO), tlp_* (framed output stream).
// master = sender side (pops FIFOs, drives stream); slave = FIFO/link side.
interface mwr_tlp_sender_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  hdr_empty;
    logic [127:0]          hdr_rdata;
    logic                  hdr_rden;
    logic                  wd_empty;
    logic [DATA_WIDTH-1:0] wd_rdata;
    logic                  wd_rden;
    logic                  tlp_valid;
    logic                  tlp_ready;
    logic [DATA_WIDTH-1:0] tlp_data;
    logic                  tlp_sop;
    logic                  tlp_eop;
    logic [7:0]            tlp_keep;

    modport master (
        input  hdr_empty, hdr_rdata, wd_empty, wd_rdata, tlp_ready,
        output hdr_rden, wd_rden, tlp_valid, tlp_data, tlp_sop, tlp_eop, tlp_keep
    );

    modport slave (
        output hdr_empty, hdr_rdata, wd_empty, wd_rdata, tlp_ready,
        input  hdr_rden, wd_rden, tlp_valid, tlp_data, tlp_sop, tlp_eop, tlp_keep
    );
endinterface

// File: rtl/mwr_tlp_sender.sv
// Frames one memory-write TLP at a time: header beat from the AW FIFO, then its payload beats.
// Latency: header beat is offered 1 cycle after the header FIFO goes non-empty; payload follows back to back.
// Backpressure: beat held stable while tlp_ready is low; FIFOs popped only in transfer cycles.
// Ports: clk, rst (sync, active-high); bus (master modport: hdr_*, wd_*, tlp_*);
//        tlp_sent_cnt = count of completed TLPs (EOP handshakes), wraps.
module mwr_tlp_sender #(
    parameter int DATA_WIDTH = 256,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mwr_tlp_sender_if.master     bus,
    output logic [CNT_WIDTH-1:0] tlp_sent_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [7:0]           remaining, remaining_nxt;
    logic [7:0]           last_keep, last_keep_nxt;
    logic [CNT_WIDTH-1:0] cnt_nxt;

    logic [10:0] len_dw;
    logic [7:0]  hdr_beats;
    logic [7:0]  hdr_last_keep;
    logic        eop;

    // Length decode: a zero Length field encodes 1024 DW.
    always_comb begin
        len_dw        = (bus.hdr_rdata[9:0] == 10'd0) ? 11'd1024 : {1'b0, bus.hdr_rdata[9:0]};
        hdr_beats     = len_dw[10:3] + {7'd0, |len_dw[2:0]};
        hdr_last_keep = (bus.hdr_rdata[2:0] == 3'd0) ? 8'hFF
                                                     : (8'hFF >> (4'd8 - {1'b0, bus.hdr_rdata[2:0]}));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= 8'd0;
            last_keep    <= 8'd0;
            tlp_sent_cnt <= '0;
        end else begin
            state        <= state_nxt;
            remaining    <= remaining_nxt;
            last_keep    <= last_keep_nxt;
            tlp_sent_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        last_keep_nxt = last_keep;
        cnt_nxt       = tlp_sent_cnt;
        eop           = 1'b0;
        bus.tlp_valid = 1'b0;
        bus.tlp_sop   = 1'b0;
        bus.tlp_eop   = 1'b0;
        bus.tlp_keep  = 8'h00;
        bus.tlp_data  = '0;
        bus.hdr_rden  = 1'b0;
        bus.wd_rden   = 1'b0;

        case (state)
            IDLE: begin
                // Beat count is loaded here and then counted down directly in DATA.
                if (!bus.hdr_empty) begin
                    remaining_nxt = hdr_beats;
                    last_keep_nxt = hdr_last_keep;
                    state_nxt     = HDR;
                end
            end
            HDR: begin
                // Header stays at the FIFO head until popped, so it is stable while stalled.
                bus.tlp_valid = 1'b1;
                bus.tlp_sop   = 1'b1;
                bus.tlp_keep  = 8'h0F;
                bus.tlp_data  = {{(DATA_WIDTH-128){1'b0}}, bus.hdr_rdata};
                if (bus.tlp_ready) begin
                    bus.hdr_rden = 1'b1;
                    state_nxt    = DATA;
                end
            end
            DATA: begin
                eop           = (remaining == 8'd1);
                bus.tlp_valid = !bus.wd_empty;
                bus.tlp_data  = bus.wd_rdata;
                bus.tlp_eop   = eop;
                bus.tlp_keep  = eop ? last_keep : 8'hFF;
                if (!bus.wd_empty && bus.tlp_ready) begin
                    bus.wd_rden   = 1'b1;
                    remaining_nxt = remaining - 8'd1;
                    if (eop) begin
                        cnt_nxt   = tlp_sent_cnt + CNT_WIDTH'(1);
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Quiet the stream and never pop the FIFOs while reset is applied.
        if (rst) begin
            bus.tlp_valid = 1'b0;
            bus.tlp_sop   = 1'b0;
            bus.tlp_eop   = 1'b0;
            bus.tlp_keep  = 8'h00;
            bus.tlp_data  = '0;
            bus.hdr_rden  = 1'b0;
            bus.wd_rden   = 1'b0;
        end
    end
endmodule

// File: tb/tb_mwr_tlp_sender.sv
module tb_mwr_tlp_sender;
    localparam int DW = 256;
    localparam int CW = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [7:0]    keep;
    } beat_t;

    typedef struct {
        logic [9:0] len;
        int         mode;
        int         beats;
        logic [7:0] last_keep;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mwr_tlp_sender_if #(.DATA_WIDTH(DW)) bus ();
    logic [CW-1:0] tlp_sent_cnt;

    mwr_tlp_sender #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .tlp_sent_cnt (tlp_sent_cnt)
    );

    int checks   = 0;
    int failures = 0;

    logic [127:0]  hq[$];
    logic [DW-1:0] wq[$];
    beat_t         exp_q[$];

    int   ready_mode = 0;
    bit   wd_stall   = 1'b0;
    int   cyc        = 0;
    int   vis_cyc    = 0;
    int   sop_cyc    = 0;
    int   eop_cyc    = 0;
    int   wd_pops    = 0;
    int   sop_xfers  = 0;
    int   data_xfers = 0;
    logic post_eop_valid = 1'b1;
    bit   eop_last   = 1'b0;

    vec_t vecs[10];

    task automatic check(input string name, input logic [271:0] act, input logic [271:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_tlp(input logic [9:0] len, input int beats, input logic [7:0] lk);
        logic [127:0]  h;
        logic [DW-1:0] d;
        h = {$urandom, $urandom, $urandom, $urandom};
        h[9:0] = len;
        hq.push_back(h);
        exp_q.push_back('{data: {128'b0, h}, sop: 1'b1, eop: 1'b0, keep: 8'h0F});
        for (int b = 0; b < beats; b++) begin
            for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
            wq.push_back(d);
            exp_q.push_back('{data: d, sop: 1'b0, eop: (b == beats-1),
                              keep: (b == beats-1) ? lk : 8'hFF});
        end
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && hq.size() == 0) break;
        end
        if (i >= 3000) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d beats pending required=0", name, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    // FWFT FIFO model, ready generator and stream monitor / scoreboard.
    initial begin
        bit    xfer, pend_h, pend_w, prev_stall, prev_hdr_empty;
        beat_t e, stall_b;
        prev_stall     = 1'b0;
        prev_hdr_empty = 1'b1;
        bus.hdr_empty  = 1'b1;
        bus.hdr_rdata  = '0;
        bus.wd_empty   = 1'b1;
        bus.wd_rdata   = '0;
        bus.tlp_ready  = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            xfer = bus.tlp_valid && bus.tlp_ready;
            if (eop_last) begin
                post_eop_valid = bus.tlp_valid;
                eop_last = 1'b0;
            end
            if (!bus.hdr_empty && prev_hdr_empty) vis_cyc = cyc;
            prev_hdr_empty = bus.hdr_empty;
            if (rst) begin
                check("reset_outputs",
                      {bus.tlp_valid, bus.tlp_sop, bus.tlp_eop, bus.tlp_keep,
                       bus.hdr_rden, bus.wd_rden, bus.tlp_data}, '0);
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold",
                          {bus.tlp_valid, bus.tlp_data, bus.tlp_sop, bus.tlp_eop, bus.tlp_keep},
                          {1'b1, stall_b.data, stall_b.sop, stall_b.eop, stall_b.keep});
                if (xfer || bus.hdr_rden || bus.wd_rden)
                    check("pop_rule", {bus.hdr_rden, bus.wd_rden},
                          {xfer && bus.tlp_sop, xfer && !bus.tlp_sop});
                if (xfer) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=sop%0d/eop%0d required=no beat",
                                 bus.tlp_sop, bus.tlp_eop);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {bus.tlp_data, bus.tlp_sop, bus.tlp_eop, bus.tlp_keep},
                              {e.data, e.sop, e.eop, e.keep});
                    end
                    if (bus.tlp_sop) begin
                        sop_cyc = cyc;
                        sop_xfers++;
                    end else begin
                        data_xfers++;
                    end
                    if (bus.tlp_eop) begin
                        eop_cyc  = cyc;
                        eop_last = 1'b1;
                    end
                end
                if (bus.wd_rden) wd_pops++;
                prev_stall   = bus.tlp_valid && !bus.tlp_ready;
                stall_b.data = bus.tlp_data;
                stall_b.sop  = bus.tlp_sop;
                stall_b.eop  = bus.tlp_eop;
                stall_b.keep = bus.tlp_keep;
            end
            pend_h = bus.hdr_rden;
            pend_w = bus.wd_rden;

            @(posedge clk);
            #1;
            if (pend_h && hq.size() > 0) void'(hq.pop_front());
            if (pend_w && wq.size() > 0) void'(wq.pop_front());
            case (ready_mode)
                1:       bus.tlp_ready = ~bus.tlp_ready;
                2:       bus.tlp_ready = 1'($urandom_range(0, 1));
                default: bus.tlp_ready = 1'b1;
            endcase
            bus.hdr_empty = (hq.size() == 0);
            bus.hdr_rdata = (hq.size() > 0) ? hq[0] : '0;
            bus.wd_empty  = wd_stall || (wq.size() == 0);
            bus.wd_rdata  = (wq.size() > 0) ? wq[0] : '0;
        end
    end

    initial begin
        int n_tlp;
        int p0;
        int i;
        vecs[0] = '{10'd12,   0, 2,   8'h0F};
        vecs[1] = '{10'd0,    0, 128, 8'hFF};
        vecs[2] = '{10'd24,   1, 3,   8'hFF};
        vecs[3] = '{10'd1,    0, 1,   8'h01};
        vecs[4] = '{10'd7,    0, 1,   8'h7F};
        vecs[5] = '{10'd9,    1, 2,   8'h01};
        vecs[6] = '{10'd1023, 0, 128, 8'h7F};
        vecs[7] = '{10'd17,   2, 3,   8'h01};
        vecs[8] = '{10'd1017, 2, 128, 8'h01};
        vecs[9] = '{10'd3,    1, 1,   8'h07};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cnt", 272'(tlp_sent_cnt), 272'(0));
        @(posedge clk);
        #2 rst = 1'b0;

        // Single-beat TLP: IDLE -> HDR -> DATA -> IDLE in three cycles.
        push_tlp(10'd8, 1, 8'hFF);
        wait_done("len8");
        check("len8_hdr_latency", 272'(sop_cyc - vis_cyc), 272'(1));
        check("len8_eop_latency", 272'(eop_cyc - sop_cyc), 272'(1));
        check("len8_idle_after",  272'(post_eop_valid), 272'(0));
        n_tlp = 1;
        check("len8_cnt", 272'(tlp_sent_cnt), 272'(n_tlp % 8));

        for (int v = 0; v < 10; v++) begin
            ready_mode = vecs[v].mode;
            p0 = wd_pops;
            push_tlp(vecs[v].len, vecs[v].beats, vecs[v].last_keep);
            wait_done("vec");
            check("vec_wd_pops", 272'(wd_pops - p0), 272'(vecs[v].beats));
            n_tlp++;
            check("vec_cnt", 272'(tlp_sent_cnt), 272'(n_tlp % 8));
        end
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #2;

        // Payload FIFO empty right after the header beat.
        wd_stall = 1'b1;
        p0 = sop_xfers;
        push_tlp(10'd16, 2, 8'hFF);
        for (i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sop_xfers != p0) break;
        end
        if (i >= 200) begin
            checks++;
            failures++;
            $display("FAIL stall_hdr_timeout actual=no header beat required=header beat");
        end
        repeat (5) begin
            @(negedge clk);
            check("wd_empty_hold", {bus.tlp_valid, bus.wd_rden}, 272'(0));
        end
        @(posedge clk);
        #2 wd_stall = 1'b0;
        wait_done("wd_stall");
        n_tlp++;
        check("wd_stall_cnt", 272'(tlp_sent_cnt), 272'(n_tlp % 8));

        // Reset during the second data beat of a 4-beat TLP.
        p0 = data_xfers;
        push_tlp(10'd32, 4, 8'hFF);
        for (i = 0; i < 200; i++) begin
            @(posedge clk);
            if (data_xfers != p0) break;
        end
        if (i >= 200) begin
            checks++;
            failures++;
            $display("FAIL rst_seq_timeout actual=no data beat required=data beat");
        end
        #2 rst = 1'b1;
        hq.delete();
        wq.delete();
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_outputs", {bus.tlp_valid, bus.tlp_sop, bus.tlp_eop, bus.tlp_keep,
                                  bus.hdr_rden, bus.wd_rden}, 272'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_cnt", 272'(tlp_sent_cnt), 272'(0));
        check("rst_mid_idle", 272'(bus.tlp_valid), 272'(0));
        push_tlp(10'd8, 1, 8'hFF);
        wait_done("post_rst");
        check("post_rst_cnt", 272'(tlp_sent_cnt), 272'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
